alu_result_stage: RTL

// - Execute-to-writeback stage directly downstream of the ALU; registers ALU result, destination and flags.
// - Holds the architectural Z/N flag register, updated only by CMP (op 2).
// - Evaluates each instruction's condition code against those flags and decides whether writeback happens.
// - Valid/ready handshake on both sides, with a 2-entry skid buffer so in_ready is fully registered.

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/skid_buffer2.sv | 70 +++++++
 rtl/alu_result_stage.sv | 98 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, condition codes and the condition evaluator.
package alu_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned COND_W = 4;

  localparam logic [OP_W-1:0] ALU_OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] ALU_OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] ALU_OP_CMP = 4'd2;
  localparam logic [OP_W-1:0] ALU_OP_AND = 4'd3;
  localparam logic [OP_W-1:0] ALU_OP_OR  = 4'd4;
  localparam logic [OP_W-1:0] ALU_OP_XOR = 4'd5;
  localparam logic [OP_W-1:0] ALU_OP_SHR = 4'd14;
  localparam logic [OP_W-1:0] ALU_OP_SHL = 4'd15;

  localparam logic [COND_W-1:0] COND_EQ = 4'd0;
  localparam logic [COND_W-1:0] COND_NE = 4'd1;
  localparam logic [COND_W-1:0] COND_LT = 4'd2;
  localparam logic [COND_W-1:0] COND_GE = 4'd3;
  localparam logic [COND_W-1:0] COND_GT = 4'd4;
  localparam logic [COND_W-1:0] COND_LE = 4'd5;
  localparam logic [COND_W-1:0] COND_AL = 4'd14;

  // Unlisted codes never pass, so the beat is squashed.
  function automatic logic cond_pass(input logic [COND_W-1:0] cond,
                                     input logic z,
                                     input logic n);
    logic pass;
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_LT: pass = n;
      COND_GE: pass = !n;
      COND_GT: pass = !z && !n;
      COND_LE: pass = z || n;
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/skid_buffer2.sv
// Two-entry valid/ready skid register; in_ready_o is a flop so the upstream path is registered.
module skid_buffer2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             main_vld_q, main_vld_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic             skid_vld_q, skid_vld_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             rdy_q, rdy_d;
  logic             accept;
  logic             drain;

  assign accept = in_valid_i & rdy_q;
  assign drain  = main_vld_q & out_ready_i;

  // Main refills from skid first to keep FIFO order; otherwise a stalled accept parks in skid.
  always_comb begin
    main_vld_d  = main_vld_q;
    main_data_d = main_data_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    if (!main_vld_q || drain) begin
      if (skid_vld_q) begin
        main_vld_d  = 1'b1;
        main_data_d = skid_data_q;
        skid_vld_d  = 1'b0;
      end else begin
        main_vld_d = accept;
        if (accept) begin
          main_data_d = in_data_i;
        end
      end
    end else if (accept) begin
      skid_vld_d  = 1'b1;
      skid_data_d = in_data_i;
    end
    rdy_d = !skid_vld_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_vld_q  <= 1'b0;
      main_data_q <= '0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      rdy_q       <= 1'b0;
    end else begin
      main_vld_q  <= main_vld_d;
      main_data_q <= main_data_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      rdy_q       <= rdy_d;
    end
  end

  assign in_ready_o  = rdy_q;
  assign out_valid_o = main_vld_q;
  assign out_data_o  = main_data_q;

endmodule

// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage: Z/N flag register, condition evaluation and skid-buffered result.
// Optional ALU_FWD_EN adds fwd_valid/fwd_rd/fwd_data bypass outputs from the main register.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [OP_W-1:0]   in_op,
  input  logic              in_zr,
  input  logic              in_neg,
  input  logic [COND_W-1:0] in_cond,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_wr_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_we,
  output logic              flag_z,
  output logic              flag_n
`ifdef ALU_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  localparam int unsigned PAY_W = DATA_W + REG_AW + 1;

  logic             flag_z_q, flag_z_d;
  logic             flag_n_q, flag_n_d;
  logic             accept;
  logic             is_cmp;
  logic             cond_ok;
  logic             beat_we;
  logic [PAY_W-1:0] pay_in;
  logic [PAY_W-1:0] pay_out;

  // Condition sees the flags as they stand before this beat; a CMP updates them only if it passes.
  always_comb begin
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    accept   = in_valid & in_ready;
    is_cmp   = (in_op == ALU_OP_CMP);
    cond_ok  = cond_pass(in_cond, flag_z_q, flag_n_q);
    beat_we  = in_wr_en & cond_ok & !is_cmp;
    if (accept && is_cmp && cond_ok) begin
      flag_z_d = in_zr;
      flag_n_d = in_neg;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else begin
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
    end
  end

  assign pay_in = {in_result, in_rd, beat_we};

  skid_buffer2 #(
    .WIDTH (PAY_W)
  ) u_skid (
    .clk_i       (clock),
    .rst_i       (reset),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (pay_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (pay_out)
  );

  assign out_result = pay_out[PAY_W-1 -: DATA_W];
  assign out_rd     = pay_out[REG_AW:1];
  assign out_we     = pay_out[0];
  assign flag_z     = flag_z_q;
  assign flag_n     = flag_n_q;

`ifdef ALU_FWD_EN
  // Bypass for the operand stage: only beats that will actually write are forwarded.
  assign fwd_valid = out_valid & out_we;
  assign fwd_rd    = out_rd;
  assign fwd_data  = out_result;
`endif

endmodule
